// File: rtl/qsys_onchip_ram_ctrl.sv
// rtl/qsys_onchip_ram_ctrl.sv - Avalon-MM on-chip RAM slave with read pipeline and clear engine
// Memory is inferred; contents are never reset, only overwritten by the clear engine or accepted writes.
module qsys_onchip_ram_ctrl #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 12,
  parameter int                    DEPTH          = 2250,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    clear_req,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    busy,
  output logic                    oob_error
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    clearing, clr_last, addr_oob;
  logic                    accept, wr_acc, rd_acc;
  logic                    oob_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [DATA_WIDTH-1:0]   rd_raw_q, rd_word;
  logic                    rd_v_q, rd_oob_q;
  logic [DATA_WIDTH-1:0]   pipe_d_q;
  logic                    pipe_v_q;
  logic [DATA_WIDTH-1:0]   out_d, rd_hold_q;
  logic                    out_v;

  assign clearing    = (state_q == ST_CLEAR);
  assign clr_last    = (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1));
  assign addr_oob    = ({1'b0, address} >= (ADDR_WIDTH + 1)'(DEPTH));
  assign waitrequest = chipselect & (clearing | ~clken);
  assign accept      = chipselect & (read | write) & ~waitrequest;
  // A combined read+write is serviced as a write only.
  assign wr_acc      = accept & write;
  assign rd_acc      = accept & read & ~write;
  assign busy        = clearing;
  assign oob_error   = oob_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (clken) begin
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
          end
        end
        ST_CLEAR: begin
          if (clr_last) begin
            state_d   = ST_IDLE;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
          end
        end
        default: state_d = RESET_STATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clken && clearing) begin
      mem[clr_cnt_q] <= CLEAR_VALUE;
    end else if (wr_acc && !addr_oob) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byteenable[b]) begin
          mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
        end
      end
    end
  end

  // Raw array read kept reset-free so the tools can map it onto block RAM.
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      rd_raw_q <= mem[address];
    end
  end

  assign rd_word = rd_oob_q ? '0 : rd_raw_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
      oob_q     <= 1'b0;
      rd_v_q    <= 1'b0;
      rd_oob_q  <= 1'b0;
      pipe_v_q  <= 1'b0;
      pipe_d_q  <= '0;
      rd_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      if (clken) begin
        rd_v_q   <= rd_acc;
        pipe_v_q <= rd_v_q;
        if (rd_acc) begin
          rd_oob_q <= addr_oob;
        end
        if (rd_v_q) begin
          pipe_d_q <= rd_word;
        end
      end
      if (readdatavalid) begin
        rd_hold_q <= out_d;
      end
      if (clken && clearing) begin
        oob_q <= 1'b0;
      end else if (accept && addr_oob) begin
        oob_q <= 1'b1;
      end
    end
  end

  // The final stage is frozen while clken=0, so its valid is only presented in enabled cycles.
  assign out_v         = (READ_LATENCY == 2) ? pipe_v_q : rd_v_q;
  assign out_d         = (READ_LATENCY == 2) ? pipe_d_q : rd_word;
  assign readdatavalid = out_v & clken;
  assign readdata      = readdatavalid ? out_d : rd_hold_q;

endmodule
